dmem_arbiter: RTL

//   Shares the single-port data memory (Dmem: MemRW, 5-bit addr, 32-bit dataW/dataR)

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter_if : requester and Dmem bus bundle of dmem_arbiter     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ-1:0]        req_lock_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic                      mem_we_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic [DATA_W-1:0]         mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter : round-robin Dmem sharing with bounded lock          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                gnt_valid;
  logic [PTR_W-1:0]    gnt_idx;
  logic [HOLD_W-1:0]   hold_next;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return PTR_W'((int'(p) + 1) % NUM_REQ);
  endfunction

  // Reverse scan so the port closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (rst_ni) begin
      if (state_q == ST_LOCKED) begin
        if (bus.req_valid_i[owner_q]) begin
          gnt_valid = 1'b1;
          gnt_idx   = owner_q;
        end
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (bus.req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            gnt_valid = 1'b1;
            gnt_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
          end
        end
      end
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (gnt_valid) begin
      bus.req_ready_o[gnt_idx] = 1'b1;
      bus.mem_we_o    = bus.req_we_i[gnt_idx];
      bus.mem_addr_o  = bus.req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
      bus.mem_wdata_o = bus.req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    hold_next   = hold_cnt_q + HOLD_W'(1);

    if (gnt_valid) begin
      rsp_valid_d[gnt_idx] = 1'b1;
      rsp_rdata_d = bus.req_we_i[gnt_idx] ? '0 : bus.mem_rdata_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          if (bus.req_lock_i[gnt_idx] && (MAX_HOLD > 1)) begin
            state_d    = ST_LOCKED;
            owner_d    = gnt_idx;
            hold_cnt_d = HOLD_W'(1);
          end else begin
            rr_ptr_d = next_ptr(gnt_idx);
          end
        end
      end
      ST_LOCKED: begin
        // Owner dropping valid or reaching MAX_HOLD hands arbitration back.
        if (!gnt_valid || !bus.req_lock_i[owner_q] || (hold_next == HOLD_W'(MAX_HOLD))) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = next_ptr(owner_q);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
`default_nettype wire
